sink_list_pruner: RTL and testbench
===================================

SINK_LIST_PRUNER -- requirements
Module: sink_list_pruner

Interface
REQ-001 Parameter WORD_WIDTH, 16, memory word width.
REQ-002 Parameter ADDR_WIDTH, 11, byte address width; word stride is 2 bytes.
REQ-003 Parameter MAX_NBR, 64, neighbor table depth.
REQ-004 Parameter MAX_SINKS, 8, sinkID slots per neighbor.
REQ-005 Parameter MAX_KNOWN, 16, knownSinks table depth.
REQ-006 Parameters KNOWN_BASE 0x008, SINKID_BASE 0x248, SINKCNT_BASE 0x68E, KNOWNCNT_ADDR 0x688, NBRCNT_ADDR 0x68A are memory map base addresses.
REQ-007 clock  in  1  sole clock; all logic on rising edge.
REQ-008 nrst  in  1  synchronous, active-low reset.
REQ-009 en  in  1  high = run; low = pause.
REQ-010 start  in  1  level request, driven by the preceding stage's done.
REQ-011 address  out  ADDR_WIDTH  memory byte address.
REQ-012 wr_en  out  1  memory write strobe.
REQ-013 data_in  in  WORD_WIDTH  memory read data, valid one cycle after address is presented.
REQ-014 data_out  out  WORD_WIDTH  memory write data.
REQ-015 done  out  1  pass complete.
REQ-016 busy  out  1  pass in progress.
REQ-017 pruned_total  out  16  entries removed in last pass, saturating at 0xFFFF.

Function
REQ-018 Addressing SHALL be: knownSinks[i] = KNOWN_BASE+2i; sinkID[n][k] = SINKID_BASE+2(n*MAX_SINKS+k); sinkIDCount[n] = SINKCNT_BASE+2n.
REQ-019 FSM states SHALL be IDLE, RD_CNT, LOAD_KNOWN, RD_NCNT, RD_SLOT, CMP, WR_SLOT, CLR_SLOT, WR_NCNT, DONE.
REQ-020 IDLE->RD_CNT when start=1 and en=1; busy=1 from the next cycle until DONE is entered.
REQ-021 RD_CNT SHALL read neighborCount and knownSinkCount, clamping them to MAX_NBR and MAX_KNOWN.
REQ-022 LOAD_KNOWN SHALL cache knownSinks[0..K-1] in internal registers; K=0 makes every entry unknown.
REQ-023 Per neighbor n<N: RD_NCNT SHALL read sinkIDCount[n] clamped to MAX_SINKS (C), then reset write index w=0 and the kept-set.
REQ-024 For each slot k<C: RD_SLOT reads the ID; CMP keeps it iff it matches a cached known sink and no entry already kept for this neighbor.
REQ-025 On a kept entry, WR_SLOT SHALL write it to slot w only when w!=k, then increment w; a kept entry with w==k SHALL cause no write.
REQ-026 Each dropped entry SHALL increment the pruned counter.
REQ-027 After slot C-1, CLR_SLOT SHALL write 0x0000 to slots w..C-1.
REQ-028 WR_NCNT SHALL then write sinkIDCount[n]=w.
REQ-029 After neighbor N-1, or immediately when N=0, the FSM SHALL enter DONE and load pruned_total.
REQ-030 DONE SHALL hold done=1 while start=1, and return to IDLE the cycle after start=0; one pass runs per start assertion.
REQ-031 wr_en SHALL be high only in WR_SLOT, CLR_SLOT and WR_NCNT, for one cycle per word.
REQ-032 en=0 mid-pass SHALL freeze state and counters, force wr_en=0 and hold address; on resume the pending read SHALL be reissued (one extra latency cycle).
REQ-033 start falling mid-pass SHALL be ignored; the pass completes.
REQ-034 Equal IDs within a neighbor: the first occurrence is kept and later ones are dropped.

Reset
REQ-035 nrst=0 at a rising edge SHALL force IDLE, address=0, wr_en=0, data_out=0, done=0, busy=0, pruned_total=0, and clear all counters and caches, including mid-pass.
REQ-036 Memory contents written before reset SHALL remain; the block SHALL NOT undo partial writes.

Verification
REQ-037 known={5,9}, N=1, sinkIDs[0]={5,7,9}, C=3, start=1 -> slots {5,9,0}, count 2, pruned_total=1, done=1.
REQ-038 known={3}, N=2, n0={3,3,3}, n1={4} -> n0={3,0,0} count 1, n1={0} count 0, pruned_total=3.
REQ-039 N=0, start=1 -> DONE within 4 cycles, no wr_en pulse, pruned_total=0.
REQ-040 sinkIDCount[0]=12 with MAX_SINKS=8 -> only 8 slots processed, count written <=8.
REQ-041 en=0 for 5 cycles mid-RD_SLOT -> wr_en stays 0, final memory image identical to the uninterrupted run.
REQ-042 nrst=0 during WR_SLOT, then start held high -> all outputs at reset values, then one full pass with correct final counts.

Source files
------------

// File: rtl/sink_list_pruner.sv
// sink_list_pruner: walks every neighbor's sinkID list in memory and keeps only
// entries that appear in the knownSinks table. Duplicate IDs are kept once.
// Survivors are compacted toward slot 0, freed slots are zeroed, and the
// per-neighbor count is rewritten. The memory has a one-cycle read latency.
module sink_list_pruner #(
  parameter int WORD_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 11,
  parameter int MAX_NBR       = 64,
  parameter int MAX_SINKS     = 8,
  parameter int MAX_KNOWN     = 16,
  parameter int KNOWN_BASE    = 'h008,
  parameter int SINKID_BASE   = 'h248,
  parameter int SINKCNT_BASE  = 'h68E,
  parameter int KNOWNCNT_ADDR = 'h688,
  parameter int NBRCNT_ADDR   = 'h68A
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  wr_en,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  done,
  output logic                  busy,
  output logic [15:0]           pruned_total
);

  localparam int NW = $clog2(MAX_NBR + 1);
  localparam int KW = $clog2(MAX_KNOWN + 1);
  localparam int CW = $clog2(MAX_SINKS + 1);

  typedef enum logic [3:0] {
    IDLE, RD_CNT, LOAD_KNOWN, RD_NCNT, RD_SLOT, CMP, WR_SLOT, CLR_SLOT, WR_NCNT, DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wr;
  logic [WORD_WIDTH-1:0] r_dout;
  logic                  r_done;
  logic                  r_busy;
  logic [15:0]           r_ptot;
  logic [15:0]           r_prune;
  logic                  r_vld;   // read data for r_addr is on data_in this cycle
  logic                  r_sub;   // RD_CNT: 0 = neighborCount, 1 = knownSinkCount
  logic [NW-1:0]         r_ntot;
  logic [KW-1:0]         r_kn;
  logic [KW-1:0]         r_i;
  logic [NW-1:0]         r_n;
  logic [CW-1:0]         r_c;
  logic [CW-1:0]         r_k;     // read slot, reused as clear index in CLR_SLOT
  logic [CW-1:0]         r_w;     // compaction write index
  logic [WORD_WIDTH-1:0] r_id;
  logic [WORD_WIDTH-1:0] r_known [MAX_KNOWN];
  logic [WORD_WIDTH-1:0] r_kept  [MAX_SINKS];

  logic          w_hit, w_dup, w_keep;
  logic [CW-1:0] w_wn;

  function automatic logic [ADDR_WIDTH-1:0] f_known_addr(input logic [KW-1:0] i);
    return ADDR_WIDTH'(KNOWN_BASE + 2 * int'(i));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] f_slot_addr(input logic [NW-1:0] n,
                                                       input logic [CW-1:0] k);
    return ADDR_WIDTH'(SINKID_BASE + 2 * (int'(n) * MAX_SINKS + int'(k)));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] f_cnt_addr(input logic [NW-1:0] n);
    return ADDR_WIDTH'(SINKCNT_BASE + 2 * int'(n));
  endfunction

  assign address      = r_addr;
  assign wr_en        = r_wr & en;
  assign data_out     = r_dout;
  assign done         = r_done;
  assign busy         = r_busy;
  assign pruned_total = r_ptot;

  // Known-sink match and already-kept check for the ID under comparison.
  always_comb begin
    w_hit = 1'b0;
    w_dup = 1'b0;
    for (int i = 0; i < MAX_KNOWN; i++)
      if (i < int'(r_kn) && r_known[i] == r_id) w_hit = 1'b1;
    for (int j = 0; j < MAX_SINKS; j++)
      if (j < int'(r_w) && r_kept[j] == r_id) w_dup = 1'b1;
    w_keep = w_hit & ~w_dup;
    // Write index after this slot: a finished move, or an in-place keep.
    w_wn = r_w;
    if (r_state == WR_SLOT || (r_state == CMP && w_keep && r_w == r_k))
      w_wn = r_w + 1'b1;
  end

  // Main FSM; en low freezes everything and drops the pending read.
  always_ff @(posedge clock) begin
    if (!nrst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wr    <= 1'b0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_ptot  <= '0;
      r_prune <= '0;
      r_vld   <= 1'b0;
      r_sub   <= 1'b0;
      r_ntot  <= '0;
      r_kn    <= '0;
      r_i     <= '0;
      r_n     <= '0;
      r_c     <= '0;
      r_k     <= '0;
      r_w     <= '0;
      r_id    <= '0;
      for (int i = 0; i < MAX_KNOWN; i++) r_known[i] <= '0;
      for (int j = 0; j < MAX_SINKS; j++) r_kept[j] <= '0;
    end else if (!en) begin
      // Address is held; the read is reissued after resume.
      r_vld <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state <= RD_CNT;
          r_busy  <= 1'b1;
          r_prune <= '0;
          r_sub   <= 1'b0;
          r_vld   <= 1'b0;
          r_addr  <= ADDR_WIDTH'(NBRCNT_ADDR);
        end
        RD_CNT: if (!r_vld) r_vld <= 1'b1;
        else begin
          r_vld <= 1'b0;
          if (!r_sub) begin
            r_ntot <= (data_in > WORD_WIDTH'(MAX_NBR)) ? NW'(MAX_NBR) : NW'(data_in);
            if (data_in == '0) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_ptot  <= r_prune;
            end else begin
              r_sub  <= 1'b1;
              r_addr <= ADDR_WIDTH'(KNOWNCNT_ADDR);
            end
          end else begin
            r_kn <= (data_in > WORD_WIDTH'(MAX_KNOWN)) ? KW'(MAX_KNOWN) : KW'(data_in);
            r_n  <= '0;
            if (data_in == '0) begin
              r_state <= RD_NCNT;
              r_addr  <= f_cnt_addr('0);
            end else begin
              r_state <= LOAD_KNOWN;
              r_i     <= '0;
              r_addr  <= f_known_addr('0);
            end
          end
        end
        LOAD_KNOWN: if (!r_vld) r_vld <= 1'b1;
        else begin
          r_vld <= 1'b0;
          for (int i = 0; i < MAX_KNOWN; i++)
            if (i == int'(r_i)) r_known[i] <= data_in;
          if (r_i + 1'b1 < r_kn) begin
            r_i    <= r_i + 1'b1;
            r_addr <= f_known_addr(r_i + 1'b1);
          end else begin
            r_state <= RD_NCNT;
            r_addr  <= f_cnt_addr('0);
          end
        end
        RD_NCNT: if (!r_vld) r_vld <= 1'b1;
        else begin
          // w=0 empties the kept set; stale r_kept entries are never looked at.
          r_vld <= 1'b0;
          r_c   <= (data_in > WORD_WIDTH'(MAX_SINKS)) ? CW'(MAX_SINKS) : CW'(data_in);
          r_w   <= '0;
          r_k   <= '0;
          if (data_in == '0) begin
            r_state <= WR_NCNT;
            r_dout  <= '0;
            r_wr    <= 1'b1;
          end else begin
            r_state <= RD_SLOT;
            r_addr  <= f_slot_addr(r_n, '0);
          end
        end
        RD_SLOT: if (!r_vld) r_vld <= 1'b1;
        else begin
          r_vld   <= 1'b0;
          r_id    <= data_in;
          r_state <= CMP;
        end
        CMP, WR_SLOT: begin
          if (r_state == CMP && w_keep) begin
            for (int j = 0; j < MAX_SINKS; j++)
              if (j == int'(r_w)) r_kept[j] <= r_id;
          end
          if (r_state == CMP && !w_keep && r_prune != 16'hFFFF)
            r_prune <= r_prune + 1'b1;
          if (r_state == CMP && w_keep && r_w != r_k) begin
            r_state <= WR_SLOT;
            r_addr  <= f_slot_addr(r_n, r_w);
            r_dout  <= r_id;
            r_wr    <= 1'b1;
          end else begin
            r_w  <= w_wn;
            r_wr <= 1'b0;
            if (r_k + 1'b1 < r_c) begin
              r_state <= RD_SLOT;
              r_k     <= r_k + 1'b1;
              r_addr  <= f_slot_addr(r_n, r_k + 1'b1);
            end else if (w_wn < r_c) begin
              r_state <= CLR_SLOT;
              r_k     <= w_wn;
              r_addr  <= f_slot_addr(r_n, w_wn);
              r_dout  <= '0;
              r_wr    <= 1'b1;
            end else begin
              r_state <= WR_NCNT;
              r_addr  <= f_cnt_addr(r_n);
              r_dout  <= WORD_WIDTH'(w_wn);
              r_wr    <= 1'b1;
            end
          end
        end
        CLR_SLOT: begin
          if (r_k + 1'b1 < r_c) begin
            r_k    <= r_k + 1'b1;
            r_addr <= f_slot_addr(r_n, r_k + 1'b1);
          end else begin
            r_state <= WR_NCNT;
            r_addr  <= f_cnt_addr(r_n);
            r_dout  <= WORD_WIDTH'(r_w);
          end
        end
        WR_NCNT: begin
          r_wr <= 1'b0;
          if (r_n + 1'b1 < r_ntot) begin
            r_state <= RD_NCNT;
            r_n     <= r_n + 1'b1;
            r_addr  <= f_cnt_addr(r_n + 1'b1);
          end else begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_ptot  <= r_prune;
          end
        end
        DONE: if (!start) begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sink_list_pruner.sv
// Directed bench for sink_list_pruner with a one-cycle-latency word memory.
module tb_sink_list_pruner;

  logic        clock = 1'b0;
  logic        nrst, en, start;
  logic [10:0] address;
  logic        wr_en;
  logic [15:0] data_in, data_out;
  logic        done, busy;
  logic [15:0] pruned_total;

  logic [15:0] mem [1024];
  logic        tb_we, tb_clr;
  logic [9:0]  tb_wa;
  logic [15:0] tb_wd;
  int          wr_cnt = 0;
  int          checks = 0;
  int          fails = 0;
  int          cyc, w0;

  sink_list_pruner dut (
    .clock(clock), .nrst(nrst), .en(en), .start(start), .address(address),
    .wr_en(wr_en), .data_in(data_in), .data_out(data_out), .done(done),
    .busy(busy), .pruned_total(pruned_total)
  );

  always #5 clock = ~clock;

  // Memory: bench backdoor load/clear, DUT writes, registered read data.
  always @(posedge clock) begin
    if (tb_clr) for (int i = 0; i < 1024; i++) mem[i] <= 16'h0;
    else if (tb_we) mem[tb_wa] <= tb_wd;
    else if (wr_en) mem[address[10:1]] <= data_out;
    if (wr_en) wr_cnt <= wr_cnt + 1;
    data_in <= mem[address[10:1]];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mw(input int baddr, input int val);
    tb_we = 1'b1; tb_wa = 10'(baddr >> 1); tb_wd = 16'(val);
    @(negedge clock);
    tb_we = 1'b0;
  endtask

  task automatic mclr();
    tb_clr = 1'b1;
    @(negedge clock);
    tb_clr = 1'b0;
  endtask

  function automatic logic [15:0] rd(input int baddr);
    return mem[baddr >> 1];
  endfunction

  // Raise start and wait (bounded) for done; busy is sampled early in the pass.
  task automatic run_pass(input string tag, output int ncyc);
    start = 1'b1;
    ncyc = 0;
    while (done !== 1'b1 && ncyc < 3000) begin
      @(negedge clock);
      ncyc++;
      if (ncyc == 2) chk({tag, "_busy"}, busy, 1);
    end
    chk({tag, "_done"}, done, 1);
  endtask

  task automatic end_pass(input string tag);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk({tag, "_idle"}, done, 0);
  endtask

  // known={5,9}, N=1, n0={5,7,9}
  task automatic load_basic();
    mclr();
    mw('h008, 5); mw('h00A, 9); mw('h688, 2); mw('h68A, 1);
    mw('h248, 5); mw('h24A, 7); mw('h24C, 9); mw('h68E, 3);
  endtask

  task automatic chk_basic(input string tag);
    chk({tag, "_s0"}, rd('h248), 5);
    chk({tag, "_s1"}, rd('h24A), 9);
    chk({tag, "_s2"}, rd('h24C), 0);
    chk({tag, "_cnt"}, rd('h68E), 2);
    chk({tag, "_pruned"}, pruned_total, 1);
  endtask

  initial begin
    nrst = 1'b0; en = 1'b1; start = 1'b0; tb_we = 1'b0; tb_clr = 1'b0;
    tb_wa = '0; tb_wd = '0;
    @(negedge clock); @(negedge clock);
    chk("rst_addr", address, 0);
    chk("rst_wr", wr_en, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pruned", pruned_total, 0);
    nrst = 1'b1;

    // Basic keep/drop/compaction.
    load_basic();
    w0 = wr_cnt;
    run_pass("basic", cyc);
    chk_basic("basic");
    chk("basic_wrs", wr_cnt - w0, 3);
    end_pass("basic");

    // Duplicates within a neighbor, and a neighbor with nothing known.
    mclr();
    mw('h008, 3); mw('h688, 1); mw('h68A, 2);
    mw('h248, 3); mw('h24A, 3); mw('h24C, 3); mw('h68E, 3);
    mw('h258, 4); mw('h690, 1);
    run_pass("dup", cyc);
    chk("dup_n0s0", rd('h248), 3);
    chk("dup_n0s1", rd('h24A), 0);
    chk("dup_n0s2", rd('h24C), 0);
    chk("dup_n0cnt", rd('h68E), 1);
    chk("dup_n1s0", rd('h258), 0);
    chk("dup_n1cnt", rd('h690), 0);
    chk("dup_pruned", pruned_total, 3);
    end_pass("dup");

    // No neighbors: quick finish, no writes.
    mclr();
    mw('h688, 2); mw('h008, 1);
    w0 = wr_cnt;
    run_pass("n0", cyc);
    chk("n0_lat_le4", (cyc <= 4) ? 1 : 0, 1);
    chk("n0_wrs", wr_cnt - w0, 0);
    chk("n0_pruned", pruned_total, 0);
    end_pass("n0");

    // Count 12 clamps to 8; the word after slot 7 is a sentinel.
    mclr();
    mw('h008, 1); mw('h00A, 2); mw('h688, 2); mw('h68A, 1); mw('h68E, 12);
    mw('h248, 1); mw('h24A, 2); mw('h24C, 1); mw('h24E, 3);
    mw('h250, 2); mw('h252, 4); mw('h254, 5); mw('h256, 6);
    mw('h258, 'hAAAA);
    run_pass("clamp", cyc);
    chk("clamp_s0", rd('h248), 1);
    chk("clamp_s1", rd('h24A), 2);
    for (int k = 2; k < 8; k++) chk("clamp_sk", rd('h248 + 2 * k), 0);
    chk("clamp_sentinel", rd('h258), 'hAAAA);
    chk("clamp_cnt", rd('h68E), 2);
    chk("clamp_pruned", pruned_total, 6);
    end_pass("clamp");

    // Pause for 5 cycles while reading slot 1.
    load_basic();
    w0 = wr_cnt;
    start = 1'b1;
    cyc = 0;
    while (!(address == 11'h24A && wr_en == 1'b0) && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    chk("pause_reach", (cyc < 200) ? 1 : 0, 1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("pause_wr", wr_en, 0);
      chk("pause_addr", address, 'h24A);
    end
    en = 1'b1;
    run_pass("pause", cyc);
    chk_basic("pause");
    chk("pause_wrs", wr_cnt - w0, 3);
    end_pass("pause");

    // Reset while writing slot 1, then a full pass with start held.
    load_basic();
    start = 1'b1;
    cyc = 0;
    while (!(address == 11'h24A && wr_en == 1'b1) && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    chk("rstmid_reach", (cyc < 200) ? 1 : 0, 1);
    nrst = 1'b0;
    @(negedge clock);
    chk("rstmid_addr", address, 0);
    chk("rstmid_wr", wr_en, 0);
    chk("rstmid_dout", data_out, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_pruned", pruned_total, 0);
    nrst = 1'b1;
    run_pass("rstmid", cyc);
    chk_basic("rstmid");
    end_pass("rstmid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
